// File: rtl/dds_wave_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : dds_wave_gen_if
// Purpose  : Bundles the control, ROM and sample signals of dds_wave_gen.
//            The master side (controller / ROM / testbench) drives the
//            control words and ROM data; the slave side (the generator)
//            drives the ROM address and the output sample stream.
// Signals  : en          1       accumulate and issue samples
//            freq_ctrl   ACC_W   frequency word
//            phase_ctrl  ADDR_W  phase offset added to the ROM address
//            wave_sel    2       0 sine, 1 square, 2 triangle, 3 sawtooth
//            rom_addr    ADDR_W  sine ROM address (registered)
//            rom_data    DATA_W  sine ROM data, valid 1 cycle after address
//            wave_out    DATA_W  output sample (registered)
//            wave_valid  1       wave_out updated this cycle
//            cycle_pulse 1       one-cycle pulse on accumulator wrap
// Revision : 1.0  initial release
// ============================================================================
interface dds_wave_gen_if #(
   parameter int ACC_W  = 32,
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
);
   logic              en;
   logic [ACC_W-1:0]  freq_ctrl;
   logic [ADDR_W-1:0] phase_ctrl;
   logic [1:0]        wave_sel;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic [DATA_W-1:0] wave_out;
   logic              wave_valid;
   logic              cycle_pulse;

   modport master (
      output en, freq_ctrl, phase_ctrl, wave_sel, rom_data,
      input  rom_addr, wave_out, wave_valid, cycle_pulse
   );

   modport slave (
      input  en, freq_ctrl, phase_ctrl, wave_sel, rom_data,
      output rom_addr, wave_out, wave_valid, cycle_pulse
   );
endinterface
`default_nettype wire

// File: rtl/dds_wave_gen.sv
`default_nettype none
// ============================================================================
// Module   : dds_wave_gen
// Purpose  : 32-bit DDS phase accumulator with phase offset, synchronous
//            sine ROM addressing and a 3-stage pipeline that emits one
//            sine/square/triangle/sawtooth sample per clock. Frequency word
//            changes are taken only at a period boundary (glitch-free).
// Ports    : sys_clk    system clock
//            sys_rst_n  synchronous, active-low reset
//            bus        dds_wave_gen_if.slave (control in, ROM and samples)
// Revision : 1.0  initial release
// ============================================================================
module dds_wave_gen #(
   parameter int ACC_W  = 32,
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
) (
   input  wire logic      sys_clk,
   input  wire logic      sys_rst_n,
   dds_wave_gen_if.slave  bus
);

   localparam logic [1:0] C_SEL_SINE   = 2'd0;
   localparam logic [1:0] C_SEL_SQUARE = 2'd1;
   localparam logic [1:0] C_SEL_TRI    = 2'd2;
   localparam logic [1:0] C_SEL_SAW    = 2'd3;

   // Accumulator state
   logic [ACC_W-1:0]  r_acc;
   logic [ACC_W-1:0]  r_freq_shadow;
   logic              r_cycle_pulse;

   // Pipeline stage 1 / 2 / 3
   logic [ADDR_W-1:0] r_rom_addr;
   logic              r_v1;
   logic [1:0]        r_sel1;
   logic [ADDR_W-1:0] r_a2;
   logic              r_v2;
   logic [1:0]        r_sel2;
   logic [DATA_W-1:0] r_wave_out;
   logic              r_wave_valid;

   // Combinational helpers
   logic [ACC_W:0]    w_sum;
   logic              w_carry;
   logic              w_shadow_load;
   logic [ADDR_W-1:0] w_addr_next;
   logic [ADDR_W-1:0] w_tri_full;
   logic [DATA_W-1:0] w_sample;

   // One extra bit on the add exposes the wrap as a carry-out.
   assign w_sum   = {1'b0, r_acc} + {1'b0, r_freq_shadow};
   assign w_carry = bus.en & w_sum[ACC_W];

   // The shadow refreshes only at a period boundary so a new word never
   // bends the current period. While idle, or while the shadow holds zero
   // (accumulator would never wrap), it tracks freq_ctrl directly.
   assign w_shadow_load = w_carry | ~bus.en | (r_freq_shadow == '0);

   assign w_addr_next = r_acc[ACC_W-1 -: ADDR_W] + bus.phase_ctrl;

   // Triangle: fold the upper half of the phase back down, doubling slope.
   assign w_tri_full = r_a2[ADDR_W-1] ? ~{r_a2[ADDR_W-2:0], 1'b0}
                                      :  {r_a2[ADDR_W-2:0], 1'b0};

   always_comb begin
      w_sample = bus.rom_data;
      case (r_sel2)
         C_SEL_SINE:   w_sample = bus.rom_data;
         C_SEL_SQUARE: w_sample = r_a2[ADDR_W-1] ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
         C_SEL_TRI:    w_sample = w_tri_full[ADDR_W-1 -: DATA_W];
         C_SEL_SAW:    w_sample = r_a2[ADDR_W-1 -: DATA_W];
         default:      w_sample = bus.rom_data;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_acc         <= '0;
         r_freq_shadow <= '0;
         r_cycle_pulse <= 1'b0;
         r_rom_addr    <= '0;
         r_v1          <= 1'b0;
         r_sel1        <= 2'd0;
         r_a2          <= '0;
         r_v2          <= 1'b0;
         r_sel2        <= 2'd0;
         r_wave_out    <= '0;
         r_wave_valid  <= 1'b0;
      end else begin
         // Accumulator
         if (bus.en) begin
            r_acc <= w_sum[ACC_W-1:0];
         end
         r_cycle_pulse <= w_carry;
         if (w_shadow_load) begin
            r_freq_shadow <= bus.freq_ctrl;
         end

         // Stage 1: address issue; select and valid travel with it so a
         // sample is never built from a mix of old and new controls.
         r_rom_addr <= w_addr_next;
         r_v1       <= bus.en;
         r_sel1     <= bus.wave_sel;

         // Stage 2: ROM read in flight, align address with its data
         r_a2   <= r_rom_addr;
         r_v2   <= r_v1;
         r_sel2 <= r_sel1;

         // Stage 3: output sample
         r_wave_valid <= r_v2;
         if (r_v2) begin
            r_wave_out <= w_sample;
         end
      end
   end

   assign bus.rom_addr    = r_rom_addr;
   assign bus.wave_out    = r_wave_out;
   assign bus.wave_valid  = r_wave_valid;
   assign bus.cycle_pulse = r_cycle_pulse;

endmodule
`default_nettype wire

// File: tb/tb_dds_wave_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_dds_wave_gen
// Purpose  : Self-checking bench for dds_wave_gen. A cycle model of the
//            phase accumulator predicts each sample from the wave formulas;
//            expected samples are queued at issue and popped by a monitor
//            whenever wave_valid is seen.
// Revision : 1.0  initial release
// ============================================================================
module tb_dds_wave_gen;

   localparam int ACC_W  = 32;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 8;
   localparam int NADDR  = 1 << ADDR_W;
   localparam longint unsigned ACC_MOD = 64'd1 << ACC_W;

   logic sys_clk;
   logic sys_rst_n;

   dds_wave_gen_if #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_if ();

   dds_wave_gen #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (u_if)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Sine ROM contents: arbitrary bytes, so a wrong address shows up.
   int rom_tbl [NADDR];
   always @(posedge sys_clk) u_if.rom_data <= DATA_W'(rom_tbl[u_if.rom_addr]);

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int exp_sample(input int a, input int sel);
      int half;
      int sh;
      half = NADDR / 2;
      sh   = ADDR_W - DATA_W;
      case (sel)
         0:       return rom_tbl[a];
         1:       return (a >= half) ? (1 << DATA_W) - 1 : 0;
         2:       return ((a < half) ? 2 * a : (NADDR - 1) - 2 * (a - half)) >> sh;
         default: return a >> sh;
      endcase
   endfunction

   // ---------------- reference model ----------------
   longint unsigned m_acc;
   longint unsigned m_shadow;
   int              exp_addr;
   int              exp_pulse;
   bit              rst_seen;
   bit              started;
   int              exp_q[$];

   always @(posedge sys_clk) begin
      longint unsigned sum;
      bit carry;
      if (!sys_rst_n) begin
         m_acc     = 0;
         m_shadow  = 0;
         exp_addr  = 0;
         exp_pulse = 0;
         exp_q.delete();
         rst_seen  = 1'b1;
         started   = 1'b1;
      end else begin
         rst_seen = 1'b0;
         exp_addr = int'(((m_acc >> (ACC_W - ADDR_W)) + longint'(u_if.phase_ctrl)) % NADDR);
         if (u_if.en) exp_q.push_back(exp_sample(exp_addr, int'(u_if.wave_sel)));
         sum       = m_acc + m_shadow;
         carry     = u_if.en && (sum >= ACC_MOD);
         exp_pulse = carry ? 1 : 0;
         if (u_if.en) m_acc = sum % ACC_MOD;
         if (carry || !u_if.en || m_shadow == 0) m_shadow = longint'(u_if.freq_ctrl);
      end
   end

   // ---------------- monitor ----------------
   int last_out = 0;

   always @(negedge sys_clk) begin
      int e;
      if (started) begin
         if (rst_seen) begin
            chk("rst_wave_out", longint'(u_if.wave_out), 0);
            chk("rst_wave_valid", longint'(u_if.wave_valid), 0);
            chk("rst_cycle_pulse", longint'(u_if.cycle_pulse), 0);
            chk("rst_rom_addr", longint'(u_if.rom_addr), 0);
            last_out = 0;
         end else begin
            chk("rom_addr", longint'(u_if.rom_addr), longint'(exp_addr));
            chk("cycle_pulse", longint'(u_if.cycle_pulse), longint'(exp_pulse));
            if (u_if.wave_valid) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_valid", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("wave_out", longint'(u_if.wave_out), longint'(e));
                  last_out = e;
               end
            end else begin
               chk("wave_hold", longint'(u_if.wave_out), longint'(last_out));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic do_reset(input int n);
      sys_rst_n = 1'b0;
      cyc(n);
      sys_rst_n = 1'b1;
   endtask

   task automatic setup(input logic e, input logic [31:0] f, input int ph, input int sel);
      u_if.en         = e;
      u_if.freq_ctrl  = f;
      u_if.phase_ctrl = ADDR_W'(ph);
      u_if.wave_sel   = 2'(sel);
   endtask

   initial begin
      for (int i = 0; i < NADDR; i++) rom_tbl[i] = int'($urandom_range(0, (1 << DATA_W) - 1));
      sys_rst_n = 1'b0;
      setup(1'b0, 32'h0, 0, 0);
      @(negedge sys_clk);
      do_reset(2);

      // Sawtooth at one address step per cycle
      setup(1'b1, 32'h0040_0000, 0, 3);
      cyc(40);

      // Half-rate: wrap every second cycle, square alternates
      do_reset(1);
      setup(1'b1, 32'h8000_0000, 0, 1);
      cyc(20);

      // Frequency change mid-period waits for the wrap
      do_reset(1);
      setup(1'b1, 32'h0040_0000, 0, 0);
      cyc(102);
      u_if.freq_ctrl = 32'h0080_0000;
      cyc(1100);

      // Phase offset with triangle
      do_reset(1);
      setup(1'b1, 32'h0040_0000, 512, 2);
      cyc(1100);

      // Mid-run reset, then idle window with held output
      do_reset(1);
      setup(1'b1, 32'h0123_4567, 100, 0);
      cyc(10);
      u_if.en = 1'b0;
      u_if.wave_sel = 2'd3;
      cyc(5);
      u_if.en = 1'b1;
      cyc(10);

      // Randomized run
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset(1);
         end
         if ($urandom_range(0, 15) == 0) u_if.en = ~u_if.en;
         if ($urandom_range(0, 31) == 0) begin
            case ($urandom_range(0, 3))
               0:       u_if.freq_ctrl = 32'h0;
               1:       u_if.freq_ctrl = $urandom_range(1, 32'h00FF_FFFF);
               default: u_if.freq_ctrl = $urandom;
            endcase
         end
         if ($urandom_range(0, 7) == 0) u_if.phase_ctrl = ADDR_W'($urandom);
         if ($urandom_range(0, 7) == 0) u_if.wave_sel = 2'($urandom);
         cyc(1);
      end

      // Drain: every issued sample must have come out
      u_if.en = 1'b0;
      cyc(6);
      chk("drain_empty", longint'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
